cm_lut_engine: RTL and testbench

- Programmable successor to the fixed custom-matrix nibble mappers.
- Holds BANKS runtime-loadable lookup tables, each with 2^IDX_W entries of DAT_W bits.
- Maps LANES parallel indices per accepted input word through the selected bank, with a 2-stage registered pipeline.
- Sits between the pin-level input bus and the registered output bus of the top level. Tables are loaded by a burst-load state machine.

---
 rtl/cm_lut_if.sv | 28 ++
 rtl/cm_lut_engine.sv | 84 ++++++++
 tb/tb_cm_lut_engine.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cm_lut_if.sv
// cm_lut_if: lookup and table-load bus for cm_lut_engine
interface cm_lut_if #(
  parameter int IDX_W = 4,
  parameter int DAT_W = 4,
  parameter int LANES = 2,
  parameter int BANKS = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [$clog2(BANKS)-1:0]   in_bank;
  logic [LANES*IDX_W-1:0]     in_data;
  logic                       out_valid;
  logic [LANES*DAT_W-1:0]     out_data;
  logic                       cfg_start;
  logic [$clog2(BANKS)-1:0]   cfg_bank;
  logic                       cfg_valid;
  logic [DAT_W-1:0]           cfg_data;
  logic                       cfg_busy;
  logic                       cfg_done;
  modport master (
    output in_valid, in_bank, in_data, cfg_start, cfg_bank, cfg_valid, cfg_data,
    input  in_ready, out_valid, out_data, cfg_busy, cfg_done
  );
  modport slave (
    input  in_valid, in_bank, in_data, cfg_start, cfg_bank, cfg_valid, cfg_data,
    output in_ready, out_valid, out_data, cfg_busy, cfg_done
  );
endinterface

// File: rtl/cm_lut_engine.sv
// cm_lut_engine: banked runtime-loadable LUT mapper, 2-stage lookup pipe plus burst-load FSM
module cm_lut_engine #(
  parameter int IDX_W = 4,
  parameter int DAT_W = 4,
  parameter int LANES = 2,
  parameter int BANKS = 4
) (
  input logic      clk,
  input logic      rst_n,
  cm_lut_if.slave  bus
);
  localparam int BW    = $clog2(BANKS);
  localparam int DEPTH = 2**IDX_W;
  typedef enum logic {IDLE, LOAD} state_t;
  state_t                 state_q, state_d;
  logic [BW-1:0]          load_bank_q, load_bank_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   done_q, done_d, we;
  logic [DAT_W-1:0]       tab_q [BANKS][DEPTH];
  logic                   s1_v_q, out_v_q, acc;
  logic [BW-1:0]          s1_bank_q;
  logic [LANES*IDX_W-1:0] s1_idx_q;
  logic [LANES*DAT_W-1:0] out_data_q, rd;
  assign bus.in_ready  = !(state_q == LOAD && bus.in_bank == load_bank_q);
  assign acc           = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_v_q;
  assign bus.out_data  = out_data_q;
  assign bus.cfg_busy  = state_q == LOAD;
  assign bus.cfg_done  = done_q;
  always_comb begin
    state_d     = state_q;
    load_bank_d = load_bank_q;
    ptr_d       = ptr_q;
    done_d      = 1'b0;
    we          = 1'b0;
    if (state_q == IDLE) begin
      if (bus.cfg_start) begin
        state_d     = LOAD;
        load_bank_d = bus.cfg_bank;
        ptr_d       = '0;
      end
    end else if (bus.cfg_valid) begin
      we     = 1'b1;
      ptr_d  = ptr_q + 1'b1;
      state_d = &ptr_q ? IDLE : LOAD;
      done_d  = &ptr_q;
    end
  end
  always_comb begin
    rd = '0;
    for (int k = 0; k < LANES; k++)
      rd[k*DAT_W +: DAT_W] = tab_q[s1_bank_q][s1_idx_q[k*IDX_W +: IDX_W]];
  end
  // Stage-2 read and table write share an edge: nonblocking gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      load_bank_q <= '0;
      ptr_q       <= '0;
      done_q      <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_bank_q   <= '0;
      s1_idx_q    <= '0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      for (int b = 0; b < BANKS; b++)
        for (int i = 0; i < DEPTH; i++)
          tab_q[b][i] <= DAT_W'(i);
    end else begin
      state_q     <= state_d;
      load_bank_q <= load_bank_d;
      ptr_q       <= ptr_d;
      done_q      <= done_d;
      s1_v_q      <= acc;
      out_v_q     <= s1_v_q;
      if (acc) begin
        s1_bank_q <= bus.in_bank;
        s1_idx_q  <= bus.in_data;
      end
      if (s1_v_q) out_data_q <= rd;
      if (we) tab_q[load_bank_q][ptr_q] <= bus.cfg_data;
    end
  end
endmodule

// File: tb/tb_cm_lut_engine.sv
// tb_cm_lut_engine: directed plan plus random traffic against a table/queue reference model
module tb_cm_lut_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int passes = 0, total = 0, done_cnt = 0;
  cm_lut_if #(.IDX_W(4), .DAT_W(4), .LANES(2), .BANKS(4)) bus ();
  cm_lut_engine #(.IDX_W(4), .DAT_W(4), .LANES(2), .BANKS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: plain tables, load progress as counters, accepted words held one edge
  int m_tab [4][16];
  bit m_load, m_done, p_v, e_v;
  int m_lb, m_ptr, p_bank;
  logic [7:0] p_data, e_data;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) for (int i = 0; i < 16; i++) m_tab[b][i] = i;
      m_load = 0; m_done = 0; m_lb = 0; m_ptr = 0; p_v = 0; e_v = 0; e_data = 0;
    end else begin
      bit a;
      e_v = p_v;
      if (p_v) e_data = {4'(m_tab[p_bank][p_data[7:4]]), 4'(m_tab[p_bank][p_data[3:0]])};
      a = bus.in_valid && !(m_load && int'(bus.in_bank) == m_lb);
      p_v = a;
      if (a) begin p_bank = int'(bus.in_bank); p_data = bus.in_data; end
      m_done = 0;
      if (!m_load) begin
        if (bus.cfg_start) begin m_load = 1; m_lb = int'(bus.cfg_bank); m_ptr = 0; end
      end else if (bus.cfg_valid) begin
        m_tab[m_lb][m_ptr] = int'(bus.cfg_data);
        m_ptr++;
        if (m_ptr == 16) begin m_load = 0; m_done = 1; m_ptr = 0; end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", bus.in_ready, !(m_load && int'(bus.in_bank) == m_lb));
    check("out_valid", bus.out_valid, e_v);
    check("out_data", bus.out_data, e_data);
    check("cfg_busy", bus.cfg_busy, m_load);
    check("cfg_done", bus.cfg_done, m_done);
    if (bus.cfg_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 0; bus.in_bank = 0; bus.in_data = 0;
    bus.cfg_start = 0; bus.cfg_bank = 0; bus.cfg_valid = 0; bus.cfg_data = 0;
  endtask

  task automatic lookup(input int bank, input logic [7:0] data, input logic [7:0] exp, input string tag);
    bus.in_valid = 1; bus.in_bank = 2'(bank); bus.in_data = data;
    tick();
    bus.in_valid = 0;
    tick();
    check({tag, "_v"}, bus.out_valid, 1);
    check({tag, "_d"}, bus.out_data, exp);
  endtask

  task automatic load_start(input int bank);
    bus.cfg_start = 1; bus.cfg_bank = 2'(bank);
    tick();
    bus.cfg_start = 0;
  endtask

  // mode 0: 15-i, mode 1: i^9, otherwise random; a stray cfg_start is raised on beat 4
  task automatic load_beats(input int first, input int last, input int mode);
    for (int i = first; i <= last; i++) begin
      bus.cfg_valid = 1;
      bus.cfg_data = mode == 0 ? 4'(15 - i) : mode == 1 ? 4'(i ^ 9) : 4'($urandom);
      bus.cfg_start = i == 4; bus.cfg_bank = 0;
      tick();
      bus.cfg_valid = 0; bus.cfg_start = 0;
      if ($urandom_range(0, 2) == 0) tick();
    end
  endtask

  initial begin
    int d0;
    idle_in();
    #1 rst_n = 0;
    repeat (2) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.cfg_busy, 0);
    check("rst_done", bus.cfg_done, 0);
    rst_n = 1;
    tick();
    lookup(2, 8'hA5, 8'hA5, "identity");
    d0 = done_cnt;
    load_start(1);
    check("load_busy", bus.cfg_busy, 1);
    load_beats(0, 15, 0);
    tick();
    check("load_done_once", done_cnt - d0, 1);
    lookup(1, 8'h30, 8'hCF, "bank1");
    d0 = done_cnt;
    load_start(3);
    bus.in_valid = 1; bus.in_bank = 3; bus.in_data = 8'h21;
    #1 check("stall_rdy", bus.in_ready, 0);
    tick();
    bus.in_bank = 0; bus.in_data = 8'h5A;
    #1 check("other_rdy", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
    tick();
    check("other_v", bus.out_valid, 1);
    check("other_d", bus.out_data, 8'h5A);
    load_beats(0, 14, 1);
    check("busy_beat15", bus.cfg_busy, 1);
    load_beats(15, 15, 1);
    tick();
    check("restart_ignored", done_cnt - d0, 1);
    lookup(3, 8'h12, 8'h8B, "bank3");
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin bus.in_valid = 1; bus.in_bank = 0; bus.in_data = 8'(i * 8'h11); end
      else bus.in_valid = 0;
      tick();
      if (i >= 1 && i <= 5) begin
        check("burst_v", bus.out_valid, 1);
        check("burst_d", bus.out_data, 8'((i - 1) * 8'h11));
      end
      if (i == 6) check("burst_end", bus.out_valid, 0);
    end
    bus.cfg_valid = 1; bus.cfg_data = 4'hF;
    repeat (3) tick();
    bus.cfg_valid = 0;
    lookup(0, 8'h96, 8'h96, "idle_cfg");
    load_start(2);
    for (int i = 0; i < 7; i++) begin
      bus.cfg_valid = 1; bus.cfg_data = 4'($urandom);
      bus.in_valid = i == 5; bus.in_bank = 0; bus.in_data = 8'h12;
      tick();
    end
    bus.cfg_valid = 0; bus.in_valid = 0;
    check("pre_rst_v", bus.out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_v", bus.out_valid, 0);
    check("mid_rst_d", bus.out_data, 0);
    check("mid_rst_busy", bus.cfg_busy, 0);
    tick();
    rst_n = 1;
    tick();
    lookup(2, 8'h7E, 8'h7E, "post_rst");
    for (int c = 0; c < 600; c++) begin
      bus.in_valid = 1'($urandom);
      bus.in_bank = 2'($urandom);
      bus.in_data = 8'($urandom);
      bus.cfg_start = $urandom_range(0, 15) == 0;
      bus.cfg_bank = 2'($urandom);
      bus.cfg_valid = $urandom_range(0, 3) != 0;
      bus.cfg_data = 4'($urandom);
      tick();
    end
    idle_in();
    repeat (40) tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
